// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between a single-cycle bus and a byte UART: 4-deep TX queue with
// start/busy handshake, and an RX snapshot of the external FIFO drained one byte per RXDATA read.
module uart_mmio_bridge (
  input  logic         clk,
  input  logic         reset,
  input  logic         bus_req,
  input  logic         bus_we,
  input  logic [3:0]   bus_addr,
  input  logic [31:0]  bus_wdata,
  output logic [31:0]  bus_rdata,
  output logic         bus_ready,
  output logic         tx_start,
  output logic [7:0]   tx_data_in,
  input  logic         tx_busy,
  output logic         read_all,
  output logic         mode,
  input  logic         flag_ready,
  input  logic [127:0] fifo_data_flat,
  input  logic         fifo_empty
);

  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_BUSY, T_WAIT_DONE} tx_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rx_state_e;

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  tx_state_e   tx_state_q, tx_state_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  txq_q [4];
  logic [1:0]  tx_wptr_q, tx_rptr_q;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  snap_q [16];
  logic [4:0]  rx_cnt_q, rx_cnt_d;
  logic [3:0]  rx_idx_q, rx_idx_d;
  logic        mode_q, auto_fetch_q;
  logic        tx_ovf_q, rx_unf_q;
  logic        bus_ready_q;
  logic [31:0] bus_rdata_q, bus_rdata_d;

  logic [1:0]  sel;
  logic        tx_push, rx_rd, st_wr, ctrl_wr;
  logic        tx_full, tx_empty, tx_pop, tx_push_ok, tx_ovf_set;
  logic        rx_fetch, rx_take, rx_unf_set;
  logic [31:0] status;
  logic        unused_bits;

  assign sel      = bus_addr[3:2];
  assign tx_push  = bus_req &  bus_we & (sel == A_TXDATA);
  assign rx_rd    = bus_req & ~bus_we & (sel == A_RXDATA);
  assign st_wr    = bus_req &  bus_we & (sel == A_STATUS);
  assign ctrl_wr  = bus_req &  bus_we & (sel == A_CTRL);

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:26], bus_wdata[23:8]};

  assign tx_full    = (tx_cnt_q == 3'd4);
  assign tx_empty   = (tx_cnt_q == 3'd0);
  assign tx_pop     = (tx_state_q == T_WAIT_DONE) & ~tx_busy;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign tx_push_ok = tx_push & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  assign rx_fetch   = (rx_state_q == R_IDLE) & auto_fetch_q & flag_ready;
  assign rx_take    = rx_rd & (rx_cnt_q != 5'd0);
  assign rx_unf_set = rx_rd & (rx_cnt_q == 5'd0);

  assign status = {6'b0, rx_unf_q, tx_ovf_q, 3'b0, rx_cnt_q, 5'b0, tx_cnt_q, 2'b0,
                   flag_ready, fifo_empty, tx_busy, (rx_cnt_q != 5'd0), tx_empty, tx_full};

  assign bus_ready  = bus_ready_q;
  assign bus_rdata  = bus_rdata_q;
  assign tx_data_in = tx_data_q;
  assign mode       = mode_q;
  assign read_all   = rx_fetch & ~reset;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_state_d = T_START;
          tx_data_d  = txq_q[tx_rptr_q];
        end
      end
      T_START: begin
        tx_start   = ~reset;
        tx_state_d = T_WAIT_BUSY;
      end
      T_WAIT_BUSY: if (tx_busy)  tx_state_d = T_WAIT_DONE;
      T_WAIT_DONE: if (!tx_busy) tx_state_d = T_IDLE;
      default:     tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push_ok && !tx_pop)      tx_cnt_d = tx_cnt_q + 3'd1;
    else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - 3'd1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_fetch) begin
          rx_state_d = R_DRAIN;
          rx_cnt_d   = mode_q ? 5'd14 : 5'd8;
          rx_idx_d   = 4'd0;
        end
      end
      R_DRAIN: begin
        if (rx_take) begin
          rx_cnt_d = rx_cnt_q - 5'd1;
          rx_idx_d = rx_idx_q + 4'd1;
          if (rx_cnt_q == 5'd1) rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Read data reflects state before this access's own side effects.
  always_comb begin
    bus_rdata_d = 32'd0;
    if (bus_req && !bus_we) begin
      case (sel)
        A_RXDATA: if (rx_take) bus_rdata_d = {24'd0, snap_q[rx_idx_q]};
        A_STATUS: bus_rdata_d = status;
        A_CTRL:   bus_rdata_d = {30'd0, auto_fetch_q, mode_q};
        default:  bus_rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= T_IDLE;
      rx_state_q   <= R_IDLE;
      tx_wptr_q    <= 2'd0;
      tx_rptr_q    <= 2'd0;
      tx_cnt_q     <= 3'd0;
      tx_data_q    <= 8'd0;
      rx_cnt_q     <= 5'd0;
      rx_idx_q     <= 4'd0;
      mode_q       <= 1'b0;
      auto_fetch_q <= 1'b0;
      tx_ovf_q     <= 1'b0;
      rx_unf_q     <= 1'b0;
      bus_ready_q  <= 1'b0;
      bus_rdata_q  <= 32'd0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_data_q   <= tx_data_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      bus_ready_q <= bus_req;
      bus_rdata_q <= bus_rdata_d;
      if (tx_push_ok) tx_wptr_q <= tx_wptr_q + 2'd1;
      if (tx_pop)     tx_rptr_q <= tx_rptr_q + 2'd1;
      if (ctrl_wr) begin
        mode_q       <= bus_wdata[0];
        auto_fetch_q <= bus_wdata[1];
      end
      // Set beats clear when both land in the same cycle.
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~(st_wr & bus_wdata[24]));
      rx_unf_q <= rx_unf_set | (rx_unf_q & ~(st_wr & bus_wdata[25]));
    end
  end

  // Storage arrays carry no reset; the pointers and counts above invalidate them.
  always_ff @(posedge clk) begin
    if (!reset && tx_push_ok) txq_q[tx_wptr_q] <= bus_wdata[7:0];
    if (!reset && rx_fetch) begin
      for (int i = 0; i < 16; i++) snap_q[i] <= fifo_data_flat[8*i +: 8];
    end
  end

endmodule
